// File: rtl/bp_be_stride_pf_gen_pkg.sv
// ============================================================================
// bp_be_pkg: shared types for the stride prefetch generator
// Rev 1.0
// ============================================================================
`default_nettype none

`define DECLARE_BP_BE_PF_ENTRY_S(vaddr_mp, stride_mp) \
    typedef struct packed {                            \
        logic [vaddr_mp-1:0]  pc;                      \
        logic [stride_mp-1:0] stride;                  \
        logic [vaddr_mp-1:0]  last_addr;               \
    } bp_be_pf_entry_s

package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_train = 2'd1,
        e_issue = 2'd2
    } bp_be_pf_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_be_stride_pf_gen_stream_table.sv
// ============================================================================
// bp_be_pf_stream_table: per-window stream table, CAM on PC, one write port
// Rev 1.0
// ============================================================================
`default_nettype none

module bp_be_pf_stream_table
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int pf_streams_p   = 4,
    localparam int idx_width_lp  = (pf_streams_p > 1) ? $clog2(pf_streams_p) : 1,
    localparam int cnt_width_lp  = $clog2(pf_streams_p + 1)
) (
    input  logic                      clk_i,
    input  logic [cnt_width_lp-1:0]   count_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    output logic                      hit_o,
    output logic [idx_width_lp-1:0]   hit_idx_o,
    input  logic                      w_v_i,
    input  logic [idx_width_lp-1:0]   w_idx_i,
    input  logic [stride_width_p-1:0] w_stride_i,
    input  logic [vaddr_width_p-1:0]  w_addr_i,
    input  logic [idx_width_lp-1:0]   r_idx_i,
    output logic [stride_width_p-1:0] r_stride_o,
    output logic [vaddr_width_p-1:0]  r_addr_o
);

    `DECLARE_BP_BE_PF_ENTRY_S(vaddr_width_p, stride_width_p);

    bp_be_pf_entry_s tbl_q [pf_streams_p];

    // Contents need no reset: only entries below count_i are ever consulted.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            tbl_q[w_idx_i] <= '{pc: pc_i, stride: w_stride_i, last_addr: w_addr_i};
        end
    end

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = pf_streams_p - 1; i >= 0; i--) begin
            if ((cnt_width_lp'(i) < count_i) && (tbl_q[i].pc == pc_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = idx_width_lp'(i);
            end
        end
    end

    assign r_stride_o = tbl_q[r_idx_i].stride;
    assign r_addr_o   = tbl_q[r_idx_i].last_addr;

endmodule

`default_nettype wire

// File: rtl/bp_be_stride_pf_gen.sv
// ============================================================================
// bp_be_stride_pf_gen: records striding loads per discovery window and issues
// block-aligned prefetches on confirm. Rev 1.0
// ============================================================================
`default_nettype none

module bp_be_stride_pf_gen
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p        = 39,
    parameter int stride_width_p       = 8,
    parameter int pf_streams_p         = 4,
    parameter int pf_degree_p          = 2,
    parameter int block_offset_width_p = 6
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      stride_v_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    input  logic                      start_discovery_i,
    input  logic                      confirm_discovery_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_vaddr_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o
);

    localparam int idx_width_lp = (pf_streams_p > 1) ? $clog2(pf_streams_p) : 1;
    localparam int cnt_width_lp = $clog2(pf_streams_p + 1);
    localparam int deg_width_lp = (pf_degree_p > 1) ? $clog2(pf_degree_p) : 1;

    bp_be_pf_state_e           state_q, state_d;
    logic [cnt_width_lp-1:0]   count_q, count_d;
    logic [cnt_width_lp-1:0]   ptr_q, ptr_d;
    logic [deg_width_lp-1:0]   k_q, k_d;
    logic [vaddr_width_p-1:0]  cur_q, cur_d;
    logic                      pf_v_q, pf_v_d;
    logic [vaddr_width_p-1:0]  pf_vaddr_q, pf_vaddr_d;
    logic                      last_v_q, last_v_d;

    logic                      tbl_hit;
    logic [idx_width_lp-1:0]   tbl_hit_idx;
    logic                      tbl_w_v;
    logic [idx_width_lp-1:0]   tbl_w_idx;
    logic [stride_width_p-1:0] tbl_r_stride;
    logic [vaddr_width_p-1:0]  tbl_r_addr;

    logic                      start_ev;
    logic [vaddr_width_p-1:0]  base;
    logic [vaddr_width_p-1:0]  cur_next;
    logic [vaddr_width_p-1:0]  cand;

    bp_be_pf_stream_table #(
        .vaddr_width_p  (vaddr_width_p),
        .stride_width_p (stride_width_p),
        .pf_streams_p   (pf_streams_p)
    ) u_table (
        .clk_i      (clk_i),
        .count_i    (count_q),
        .pc_i       (pc_i),
        .hit_o      (tbl_hit),
        .hit_idx_o  (tbl_hit_idx),
        .w_v_i      (tbl_w_v),
        .w_idx_i    (tbl_w_idx),
        .w_stride_i (stride_i),
        .w_addr_i   (eff_addr_i),
        .r_idx_i    (idx_width_lp'(ptr_q)),
        .r_stride_o (tbl_r_stride),
        .r_addr_o   (tbl_r_addr)
    );

    assign start_ev = stride_v_i & start_discovery_i;

    // First step of each entry starts from the table, avoiding any forwarding
    // of a same-cycle update made by the confirming event.
    assign base     = (k_q == '0) ? tbl_r_addr : cur_q;
    assign cur_next = base + {{(vaddr_width_p-stride_width_p){tbl_r_stride[stride_width_p-1]}},
                              tbl_r_stride};
    assign cand     = {cur_next[vaddr_width_p-1:block_offset_width_p],
                       {block_offset_width_p{1'b0}}};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        k_d        = k_q;
        cur_d      = cur_q;
        pf_v_d     = pf_v_q;
        pf_vaddr_d = pf_vaddr_q;
        last_v_d   = last_v_q;
        tbl_w_v    = 1'b0;
        tbl_w_idx  = '0;

        case (state_q)
            e_idle: begin
                if (start_ev) begin
                    tbl_w_v = 1'b1;
                    count_d = cnt_width_lp'(1);
                    state_d = e_train;
                end
            end
            e_train: begin
                if (start_ev) begin
                    tbl_w_v = 1'b1;
                    count_d = cnt_width_lp'(1);
                end else if (stride_v_i) begin
                    if (tbl_hit) begin
                        tbl_w_v   = 1'b1;
                        tbl_w_idx = tbl_hit_idx;
                    end else if (count_q < cnt_width_lp'(pf_streams_p)) begin
                        tbl_w_v   = 1'b1;
                        tbl_w_idx = idx_width_lp'(count_q);
                        count_d   = count_q + cnt_width_lp'(1);
                    end
                    if (confirm_discovery_i) begin
                        state_d  = e_issue;
                        ptr_d    = '0;
                        k_d      = '0;
                        last_v_d = 1'b0;
                    end
                end
            end
            e_issue: begin
                if (start_ev) begin
                    tbl_w_v = 1'b1;
                    count_d = cnt_width_lp'(1);
                    pf_v_d  = 1'b0;
                    state_d = e_train;
                end else if (!pf_v_q || pf_ready_and_i) begin
                    pf_v_d = 1'b0;
                    if (ptr_q == count_q) begin
                        state_d = e_idle;
                        count_d = '0;
                    end else if (tbl_r_stride == '0) begin
                        ptr_d = ptr_q + cnt_width_lp'(1);
                        k_d   = '0;
                    end else begin
                        cur_d = cur_next;
                        // pf_vaddr_q holds the last accepted block of this phase.
                        if (!last_v_q || (cand != pf_vaddr_q)) begin
                            pf_v_d     = 1'b1;
                            pf_vaddr_d = cand;
                            last_v_d   = 1'b1;
                        end
                        if (k_q == deg_width_lp'(pf_degree_p - 1)) begin
                            k_d   = '0;
                            ptr_d = ptr_q + cnt_width_lp'(1);
                        end else begin
                            k_d = k_q + deg_width_lp'(1);
                        end
                    end
                end
            end
            default: state_d = e_idle;
        endcase

        if (flush_i) begin
            state_d = e_idle;
            count_d = '0;
            pf_v_d  = 1'b0;
            tbl_w_v = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            count_q    <= '0;
            ptr_q      <= '0;
            k_q        <= '0;
            cur_q      <= '0;
            pf_v_q     <= 1'b0;
            pf_vaddr_q <= '0;
            last_v_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            k_q        <= k_d;
            cur_q      <= cur_d;
            pf_v_q     <= pf_v_d;
            pf_vaddr_q <= pf_vaddr_d;
            last_v_q   <= last_v_d;
        end
    end

    assign pf_v_o     = pf_v_q;
    assign pf_vaddr_o = pf_vaddr_q;
    assign busy_o     = (state_q != e_idle);

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stride_pf_gen.sv
// ============================================================================
// tb_bp_be_stride_pf_gen: scoreboard bench for the stride prefetch generator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bp_be_stride_pf_gen;

    localparam int VA  = 32;
    localparam int SW  = 8;
    localparam int NS  = 4;
    localparam int DEG = 2;
    localparam int BO  = 6;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic          stride_v_i;
    logic [SW-1:0] stride_i;
    logic [VA-1:0] pc_i;
    logic [VA-1:0] eff_addr_i;
    logic          start_discovery_i;
    logic          confirm_discovery_i;
    logic          pf_v_o;
    logic [VA-1:0] pf_vaddr_o;
    logic          pf_ready_and_i;
    logic          busy_o;

    bp_be_stride_pf_gen #(
        .vaddr_width_p        (VA),
        .stride_width_p       (SW),
        .pf_streams_p         (NS),
        .pf_degree_p          (DEG),
        .block_offset_width_p (BO)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .flush_i             (flush_i),
        .stride_v_i          (stride_v_i),
        .stride_i            (stride_i),
        .pc_i                (pc_i),
        .eff_addr_i          (eff_addr_i),
        .start_discovery_i   (start_discovery_i),
        .confirm_discovery_i (confirm_discovery_i),
        .pf_v_o              (pf_v_o),
        .pf_vaddr_o          (pf_vaddr_o),
        .pf_ready_and_i      (pf_ready_and_i),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VA-1:0] pc;
        int            stride;
        logic [VA-1:0] addr;
    } ent_t;

    ent_t          tbl[$];
    bit            m_train = 1'b0;
    logic [VA-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            ready_rand = 1'b0;
    bit            ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk each recorded stream pf_degree times, drop repeated blocks.
    function automatic void gen_expected();
        logic [VA-1:0] cur, cand, last;
        bit have;
        have = 1'b0;
        last = '0;
        foreach (tbl[i]) begin
            if (tbl[i].stride == 0) continue;
            cur = tbl[i].addr;
            for (int k = 0; k < DEG; k++) begin
                cur  = cur + VA'(tbl[i].stride);
                cand = cur - (cur % (VA'(1) << BO));
                if (!have || cand != last) begin
                    exp_q.push_back(cand);
                    last = cand;
                    have = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_event(bit st, bit cf, logic [VA-1:0] pc, int s, logic [VA-1:0] a);
        ent_t e;
        int   idx;
        e.pc = pc; e.stride = s; e.addr = a;
        idx = -1;
        if (st) begin
            tbl.delete();
            tbl.push_back(e);
            m_train = 1'b1;
        end else if (m_train) begin
            foreach (tbl[i]) if (tbl[i].pc == pc && idx < 0) idx = i;
            if (idx >= 0) begin
                tbl[idx].stride = s;
                tbl[idx].addr   = a;
            end else if (tbl.size() < NS) begin
                tbl.push_back(e);
            end
            if (cf) begin
                gen_expected();
                tbl.delete();
                m_train = 1'b0;
            end
        end
    endfunction

    function automatic void model_clear();
        tbl.delete();
        m_train = 1'b0;
    endfunction

    task automatic next_cycle();
        @(negedge clk_i);
        pf_ready_and_i      = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
        stride_v_i          = 1'b0;
        start_discovery_i   = 1'b0;
        confirm_discovery_i = 1'b0;
        flush_i             = 1'b0;
        pc_i                = $urandom;
        stride_i            = SW'($urandom);
        eff_addr_i          = $urandom;
    endtask

    task automatic ev(input bit v, input bit st, input bit cf,
                      input logic [VA-1:0] pc, input int s, input logic [VA-1:0] a);
        next_cycle();
        stride_v_i          = v;
        start_discovery_i   = st;
        confirm_discovery_i = cf;
        pc_i                = pc;
        stride_i            = SW'(s);
        eff_addr_i          = a;
        if (v) model_event(st, cf, pc, s, a);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (busy_o && n < 400);
        check({name, "_busy_timeout"}, 64'(busy_o), 64'd0);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [VA-1:0] rpc();
        return 32'h1000 + 32'(4 * $urandom_range(0, 5));
    endfunction

    function automatic int rstride();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 64;
            2:       return -64;
            3:       return 8;
            4:       return -16;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    function automatic logic [VA-1:0] raddr();
        if ($urandom_range(0, 4) == 0) return 32'hFFFF_FF80 + 32'($urandom_range(0, 127));
        return $urandom;
    endfunction

    // Monitor: every accepted request must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            #4;
            if (pf_v_o && pf_ready_and_i && !reset_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req got %h expected none", pf_vaddr_o);
                end else begin
                    logic [VA-1:0] e;
                    e = exp_q.pop_front();
                    if (pf_vaddr_o !== e) begin
                        errors++;
                        $display("FAIL req_addr got %h expected %h", pf_vaddr_o, e);
                    end
                end
            end
            if (reset_i || flush_i || (stride_v_i && start_discovery_i)) exp_q.delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i             = 1'b1;
        flush_i             = 1'b0;
        stride_v_i          = 1'b0;
        start_discovery_i   = 1'b0;
        confirm_discovery_i = 1'b0;
        stride_i            = '0;
        pc_i                = '0;
        eff_addr_i          = '0;
        pf_ready_and_i      = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_pf_v", 64'(pf_v_o), 64'd0);
        check("rst_pf_vaddr", 64'(pf_vaddr_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        reset_i = 1'b0;

        // Single stream, latency and back-to-back issue
        ready_force = 1'b1;
        ev(1, 1, 0, 'h100, 64, 'h8000);
        ev(1, 0, 1, 'h100, 64, 'h8040);
        check("train_busy", 64'(busy_o), 64'd1);
        next_cycle();
        check("lat_n1_pf_v", 64'(pf_v_o), 64'd0);
        next_cycle();
        check("lat_n2_pf_v", 64'(pf_v_o), 64'd1);
        check("lat_n2_vaddr", 64'(pf_vaddr_o), 64'h8080);
        next_cycle();
        check("b2b_pf_v", 64'(pf_v_o), 64'd1);
        check("b2b_vaddr", 64'(pf_vaddr_o), 64'h80C0);
        wait_idle("single");

        // Handshake stall
        ready_force = 1'b0;
        ev(1, 1, 0, 'h100, 64, 'h8000);
        ev(1, 0, 1, 'h100, 64, 'h8040);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            check("stall_pf_v", 64'(pf_v_o), 64'd1);
            check("stall_vaddr", 64'(pf_vaddr_o), 64'h8080);
            if (i < 4) next_cycle();
        end
        ready_force = 1'b1;
        wait_idle("stall");

        // Sub-block stride: duplicate block skipped
        ev(1, 1, 0, 'h200, 8, 'h8030);
        ev(1, 0, 1, 'h200, 8, 'h8038);
        wait_idle("subblock");

        // Full table, fifth PC dropped, negative stride, random ready
        ready_rand = 1'b1;
        ev(1, 1, 0, 'h10, -16, 'h2000);
        ev(1, 0, 0, 'h20, 64, 'h3000);
        ev(1, 0, 0, 'h30, -64, 'h4000);
        ev(1, 0, 0, 'h40, 8, 'h5000);
        ev(1, 0, 0, 'h50, 64, 'h6000);
        ev(1, 0, 1, 'h10, -16, 'h1000);
        wait_idle("full");
        ready_rand = 1'b0;

        // Abort by start after one accept
        ready_force = 1'b1;
        ev(1, 1, 0, 'h300, 64, 'h9000);
        ev(1, 0, 1, 'h300, 64, 'h9000);
        next_cycle();
        next_cycle();
        ready_force = 1'b0;
        ev(1, 1, 0, 'h400, 32, 'hA000);
        check("abort_pending_v", 64'(pf_v_o), 64'd1);
        next_cycle();
        check("abort_pf_v", 64'(pf_v_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd1);
        ready_force = 1'b1;
        ev(1, 0, 1, 'h400, 32, 'hA000);
        wait_idle("abort");

        // Flush mid-issue beats a same-cycle start
        ready_force = 1'b0;
        ev(1, 1, 0, 'h100, 64, 'h8000);
        ev(1, 0, 1, 'h100, 64, 'h8040);
        next_cycle();
        next_cycle();
        check("pre_flush_pf_v", 64'(pf_v_o), 64'd1);
        next_cycle();
        flush_i           = 1'b1;
        stride_v_i        = 1'b1;
        start_discovery_i = 1'b1;
        pc_i              = 'h500;
        model_clear();
        next_cycle();
        check("flush_pf_v", 64'(pf_v_o), 64'd0);
        check("flush_busy", 64'(busy_o), 64'd0);
        ready_force = 1'b1;
        ev(1, 0, 1, 'h100, 64, 'h8040);
        repeat (8) next_cycle();
        check("flush_confirm_busy", 64'(busy_o), 64'd0);

        // Asynchronous reset mid-issue
        ready_force = 1'b0;
        ev(1, 1, 0, 'h100, 64, 'h8000);
        ev(1, 0, 1, 'h100, 64, 'h8040);
        next_cycle();
        next_cycle();
        check("pre_reset_pf_v", 64'(pf_v_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        check("async_rst_pf_v", 64'(pf_v_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        model_clear();
        next_cycle();
        reset_i     = 1'b0;
        ready_force = 1'b1;
        ev(1, 0, 1, 'h100, 64, 'h8040);
        repeat (8) next_cycle();
        check("reset_confirm_busy", 64'(busy_o), 64'd0);

        // Randomized discovery windows
        ready_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int ne;
            ne = $urandom_range(1, 7);
            if ($urandom_range(0, 3) == 0) ev(1, 0, 1'($urandom_range(0, 1)), rpc(), rstride(), raddr());
            ev(1, 1, 0, rpc(), rstride(), raddr());
            for (int j = 0; j < ne; j++) begin
                ev(($urandom_range(0, 5) != 0), ($urandom_range(0, 11) == 0),
                   ($urandom_range(0, 5) == 0) && 1'b0, rpc(), rstride(), raddr());
            end
            ev(1, 0, 1, rpc(), rstride(), raddr());
            wait_idle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
